// File: rtl/alu_op_sequencer.sv
// Command/result sequencer in front of a combinational add/sub/pass ALU.
// Registers ALU inputs, captures the result a cycle later, flags signed overflow.
module alu_op_sequencer #(
   parameter int unsigned WIDTH = 5,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [1:0]       in_mode,
   input  logic             in_use_acc,
   output logic [WIDTH-1:0] alu_var_1,
   output logic [WIDTH-1:0] alu_var_2,
   output logic [1:0]       alu_mode,
   input  logic [WIDTH-1:0] alu_result,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_ovf,
   output logic [CNT_W-1:0] ovf_cnt,
   input  logic             ovf_clr
);

   localparam int unsigned Msb = WIDTH - 1;

   typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] var_1_q, var_2_q, result_q, acc_q;
   logic [1:0]       mode_q;
   logic             valid_q, ovf_q;
   logic [CNT_W-1:0] cnt_q;
   logic             load, capture, handshake, ovf_calc;

   always_comb begin
      state_d   = state_q;
      load      = 1'b0;
      capture   = 1'b0;
      handshake = 1'b0;
      case (state_q)
         StIdle: begin
            if (in_valid) begin
               load    = 1'b1;
               state_d = StExec;
            end
         end
         StExec: begin
            capture = 1'b1;
            state_d = StDone;
         end
         StDone: begin
            if (out_ready) begin
               handshake = 1'b1;
               state_d   = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Overflow judged on sign bits of the operands actually presented to the ALU.
   always_comb begin
      ovf_calc = 1'b0;
      case (mode_q)
         2'b00:   ovf_calc = (var_1_q[Msb] == var_2_q[Msb]) && (alu_result[Msb] != var_1_q[Msb]);
         2'b11:   ovf_calc = (var_1_q[Msb] != var_2_q[Msb]) && (alu_result[Msb] != var_1_q[Msb]);
         default: ovf_calc = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         var_1_q  <= '0;
         var_2_q  <= '0;
         mode_q   <= '0;
         result_q <= '0;
         ovf_q    <= 1'b0;
         valid_q  <= 1'b0;
         acc_q    <= '0;
         cnt_q    <= '0;
      end else begin
         state_q <= state_d;
         if (load) begin
            var_1_q <= in_use_acc ? acc_q : in_a;
            var_2_q <= in_b;
            mode_q  <= in_mode;
         end
         if (capture) begin
            result_q <= alu_result;
            ovf_q    <= ovf_calc;
            valid_q  <= 1'b1;
         end
         if (handshake) begin
            acc_q   <= result_q;
            valid_q <= 1'b0;
         end
         // Clear wins over a same-cycle increment.
         if (ovf_clr) begin
            cnt_q <= '0;
         end else if (handshake && ovf_q && !(&cnt_q)) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

   assign in_ready   = rst_n && (state_q == StIdle);
   assign alu_var_1  = var_1_q;
   assign alu_var_2  = var_2_q;
   assign alu_mode   = mode_q;
   assign out_valid  = valid_q;
   assign out_result = result_q;
   assign out_ovf    = ovf_q;
   assign ovf_cnt    = cnt_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural 5-bit add/sub/pass ALU.
module tb_alu_op_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid, in_ready, in_use_acc;
   logic [4:0] in_a, in_b;
   logic [1:0] in_mode;
   logic [4:0] alu_var_1, alu_var_2, alu_result, out_result;
   logic [1:0] alu_mode;
   logic       out_valid, out_ready, out_ovf, ovf_clr;
   logic [7:0] ovf_cnt;

   int n_vec = 0;
   int n_err = 0;

   alu_op_sequencer #(.WIDTH(5), .CNT_W(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_mode   (in_mode),
      .in_use_acc(in_use_acc),
      .alu_var_1 (alu_var_1),
      .alu_var_2 (alu_var_2),
      .alu_mode  (alu_mode),
      .alu_result(alu_result),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_result(out_result),
      .out_ovf   (out_ovf),
      .ovf_cnt   (ovf_cnt),
      .ovf_clr   (ovf_clr)
   );

   always #5 clk = ~clk;

   // ALU model: wraps modulo 32.
   always_comb begin
      case (alu_mode)
         2'b00:   alu_result = alu_var_1 + alu_var_2;
         2'b11:   alu_result = alu_var_1 - alu_var_2;
         default: alu_result = alu_var_1;
      endcase
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one command from IDLE with out_ready high; sample the DONE-cycle outputs.
   task automatic do_op(input logic [4:0] a, input logic [4:0] b, input logic [1:0] m,
                        input logic ua, output logic [4:0] r, output logic o, output logic v);
      in_valid = 1'b1; in_a = a; in_b = b; in_mode = m; in_use_acc = ua;
      tick();
      in_valid = 1'b0;
      tick();
      r = out_result; o = out_ovf; v = out_valid;
      tick();
   endtask

   task automatic test_reset();
      n_vec++;
      if ({in_ready, out_valid, out_result, out_ovf, ovf_cnt, alu_var_1, alu_var_2, alu_mode}
          !== '0) begin
         n_err++;
         $display("FAIL reset_outputs: got rdy=%b vld=%b res=%h ovf=%b cnt=%0d v1=%h v2=%h m=%b, want all 0",
                  in_ready, out_valid, out_result, out_ovf, ovf_cnt, alu_var_1, alu_var_2, alu_mode);
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      n_vec++;
      if (in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL reset_ready: got %b want 1", in_ready);
      end
   endtask

   task automatic test_add();
      in_valid = 1'b1; in_a = 5'd3; in_b = 5'd4; in_mode = 2'b00; in_use_acc = 1'b0;
      tick();
      in_valid = 1'b0;
      n_vec++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
         n_err++;
         $display("FAIL add_exec: got vld=%b rdy=%b want 0 0", out_valid, in_ready);
      end
      tick();
      n_vec++;
      if (out_valid !== 1'b1 || out_result !== 5'd7 || out_ovf !== 1'b0) begin
         n_err++;
         $display("FAIL add_done: got vld=%b res=%0d ovf=%b want 1 7 0",
                  out_valid, out_result, out_ovf);
      end
      tick();
      n_vec++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL add_idle: got rdy=%b vld=%b want 1 0", in_ready, out_valid);
      end
   endtask

   task automatic test_overflow();
      logic [4:0] r;
      logic o, v;
      do_op(5'd15, 5'd1, 2'b00, 1'b0, r, o, v);
      n_vec++;
      if (r !== 5'h10 || o !== 1'b1 || v !== 1'b1 || ovf_cnt !== 8'd1) begin
         n_err++;
         $display("FAIL ovf_add: got res=%h ovf=%b vld=%b cnt=%0d want 10 1 1 1", r, o, v, ovf_cnt);
      end
      do_op(5'h10, 5'd1, 2'b11, 1'b0, r, o, v);
      n_vec++;
      if (r !== 5'd15 || o !== 1'b1 || ovf_cnt !== 8'd2) begin
         n_err++;
         $display("FAIL ovf_sub: got res=%0d ovf=%b cnt=%0d want 15 1 2", r, o, ovf_cnt);
      end
   endtask

   task automatic test_pass();
      logic [4:0] r;
      logic o, v;
      for (int i = 1; i <= 2; i++) begin
         do_op(5'h1b, 5'd9, 2'(i), 1'b0, r, o, v);  // -5 passes through
         n_vec++;
         if (r !== 5'h1b || o !== 1'b0) begin
            n_err++;
            $display("FAIL pass_mode%0d: got res=%h ovf=%b want 1b 0", i, r, o);
         end
      end
   endtask

   task automatic test_chain();
      logic [4:0] r;
      logic o, v;
      do_op(5'd2, 5'd3, 2'b00, 1'b0, r, o, v);
      n_vec++;
      if (r !== 5'd5) begin
         n_err++;
         $display("FAIL chain_first: got %0d want 5", r);
      end
      do_op(5'd9, 5'd4, 2'b11, 1'b1, r, o, v);
      n_vec++;
      if (r !== 5'd1 || o !== 1'b0) begin
         n_err++;
         $display("FAIL chain_acc: got res=%0d ovf=%b want 1 0", r, o);
      end
   endtask

   task automatic test_back_to_back_backpressure();
      out_ready = 1'b0;
      in_valid = 1'b1; in_a = 5'd1; in_b = 5'd1; in_mode = 2'b00; in_use_acc = 1'b0;
      tick();
      in_a = 5'd9; in_b = 5'd9; in_mode = 2'b11;  // must be ignored from here on
      tick();
      for (int i = 0; i < 5; i++) begin
         n_vec++;
         if (out_valid !== 1'b1 || out_result !== 5'd2 || out_ovf !== 1'b0 || in_ready !== 1'b0
             || alu_var_1 !== 5'd1 || alu_mode !== 2'b00) begin
            n_err++;
            $display("FAIL bp_hold%0d: got vld=%b res=%0d ovf=%b rdy=%b v1=%0d m=%b want 1 2 0 0 1 00",
                     i, out_valid, out_result, out_ovf, in_ready, alu_var_1, alu_mode);
         end
         tick();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      n_vec++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL bp_release: got vld=%b rdy=%b want 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_reset_mid_op();
      logic [4:0] r;
      logic o, v;
      in_valid = 1'b1; in_a = 5'd7; in_b = 5'd7; in_mode = 2'b00; in_use_acc = 1'b0;
      tick();
      in_valid = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      n_vec++;
      if ({in_ready, out_valid, out_result, out_ovf, ovf_cnt, alu_var_1, alu_var_2, alu_mode}
          !== '0) begin
         n_err++;
         $display("FAIL abort_outputs: got rdy=%b vld=%b res=%h cnt=%0d v1=%h want all 0",
                  in_ready, out_valid, out_result, ovf_cnt, alu_var_1);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         n_vec++;
         if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL abort_no_result%0d: got vld=%b want 0", i, out_valid);
         end
      end
      do_op(5'd9, 5'd3, 2'b00, 1'b1, r, o, v);
      n_vec++;
      if (r !== 5'd3) begin
         n_err++;
         $display("FAIL abort_acc: got %0d want 3", r);
      end
   endtask

   task automatic test_saturate_clear();
      logic [4:0] r;
      logic o, v;
      for (int i = 0; i < 255; i++) do_op(5'd15, 5'd1, 2'b00, 1'b0, r, o, v);
      n_vec++;
      if (ovf_cnt !== 8'd255) begin
         n_err++;
         $display("FAIL sat_255: got %0d want 255", ovf_cnt);
      end
      for (int i = 0; i < 5; i++) do_op(5'd15, 5'd1, 2'b00, 1'b0, r, o, v);
      n_vec++;
      if (ovf_cnt !== 8'd255) begin
         n_err++;
         $display("FAIL sat_hold: got %0d want 255", ovf_cnt);
      end
      out_ready = 1'b0;
      in_valid = 1'b1; in_a = 5'd15; in_b = 5'd1; in_mode = 2'b00; in_use_acc = 1'b0;
      tick();
      in_valid = 1'b0;
      tick();
      out_ready = 1'b1;
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      n_vec++;
      if (ovf_cnt !== 8'd0 || out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL clr_priority: got cnt=%0d vld=%b want 0 0", ovf_cnt, out_valid);
      end
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_mode = '0; in_use_acc = 1'b0;
      out_ready = 1'b1; ovf_clr = 1'b0;
      #2;
      test_reset();
      test_add();
      test_overflow();
      test_pass();
      test_chain();
      test_back_to_back_backpressure();
      test_reset_mid_op();
      test_saturate_clear();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
